rv_gpio: RTL and testbench

Parametrised general-purpose I/O peripheral for the rv_core data bus. It replaces the fixed 8-bit parallel port at ffff0000 with a port of configurable width, and it occupies one 32-byte window decoded by the SoC top. Each pin has a direction control and a synchronised input, plus atomic set/clear/toggle of outputs. Per-bit rising and falling edge detection drives a level interrupt request. Read data is zero when the block is not selected, so the top can OR it into the shared `d_dr`.

---
 rtl/rv_gpio.sv | 108 ++++++++++
 tb/tb_rv_gpio.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rv_gpio.sv
// rv_gpio: parametrised GPIO peripheral with synchronised inputs, atomic set/clear/toggle and edge interrupts
//   bus  : clk, reset (sync, active-high), adr/cs/rdy/we/re/dw in, dr out (registered, 0 when no read)
//   pads : pin in (asynchronous), pout/poe out
//   irq  : level interrupt; edge logic and RISE/FALL/FLAG exist only when RV_GPIO_IRQ_EN is defined,
//          otherwise those offsets read 0, ignore writes and irq is tied low
module rv_gpio #(
  parameter int          NBITS       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RST_OUT     = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       adr,
  input  logic             cs,
  input  logic             rdy,
  input  logic [3:0]       we,
  input  logic             re,
  input  logic [31:0]      dw,
  output logic [31:0]      dr,
  output logic             irq,
  input  logic [NBITS-1:0] pin,
  output logic [NBITS-1:0] pout,
  output logic [NBITS-1:0] poe
);
  logic                              acc;
  logic [2:0]                        a;
  logic [31:0]                       be;
  logic [NBITS-1:0]                  wm, wb;
  logic [SYNC_STAGES-1:0][NBITS-1:0] sync_q;
  logic [NBITS-1:0]                  sync, pout_q, pout_d, dir_q, dir_d;
  logic [31:0]                       rd, dr_q, dr_d;
  logic                              unused_bits;
`ifdef RV_GPIO_IRQ_EN
  logic [NBITS-1:0] sync_d_q, rise_q, rise_d, fall_q, fall_d, flag_q, flag_d, ev;
  logic             irq_q;
`endif
  assign acc         = cs & rdy;
  assign a           = adr[4:2];
  assign be          = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  // wm is the lane mask of an accepted write; wb the written 1s inside it
  assign wm          = acc ? be[NBITS-1:0] : '0;
  assign wb          = dw[NBITS-1:0] & wm;
  assign sync        = sync_q[SYNC_STAGES-1];
  assign unused_bits = ^{adr[1:0], dw, be};
  always_comb begin
    pout_d = a == 3'd0 ? (pout_q & ~wm) | wb :
             a == 3'd2 ? pout_q | wb :
             a == 3'd3 ? pout_q & ~wb :
             a == 3'd4 ? pout_q ^ wb : pout_q;
    dir_d  = a == 3'd1 ? (dir_q & ~wm) | wb : dir_q;
  end
  always_comb begin
    rd = '0;
    case (a)
      3'd0: rd = 32'(sync);
      3'd1: rd = 32'(dir_q);
      3'd2: rd = 32'(pout_q);
`ifdef RV_GPIO_IRQ_EN
      3'd5: rd = 32'(rise_q);
      3'd6: rd = 32'(fall_q);
      3'd7: rd = 32'(flag_q);
`endif
      default: rd = '0;
    endcase
    dr_d = acc & re ? rd : '0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      sync_q <= '0;
      pout_q <= RST_OUT[NBITS-1:0];
      dir_q  <= '0;
      dr_q   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      pout_q <= pout_d;
      dir_q  <= dir_d;
      dr_q   <= dr_d;
    end
`ifdef RV_GPIO_IRQ_EN
  assign ev = (sync & ~sync_d_q & rise_q) | (~sync & sync_d_q & fall_q);
  // new edge events are ORed in after the W1C so a coincident set wins
  always_comb begin
    rise_d = a == 3'd5 ? (rise_q & ~wm) | wb : rise_q;
    fall_d = a == 3'd6 ? (fall_q & ~wm) | wb : fall_q;
    flag_d = (a == 3'd7 ? flag_q & ~wb : flag_q) | ev;
  end
  always_ff @(posedge clk)
    if (reset) begin
      sync_d_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      flag_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync_d_q <= sync;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      flag_q   <= flag_d;
      irq_q    <= |flag_q;
    end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
  assign dr   = dr_q;
  assign pout = pout_q;
  assign poe  = dir_q;
endmodule

// File: tb/tb_rv_gpio.sv
// tb_rv_gpio: scoreboard bench for rv_gpio with NBITS=12, SYNC_STAGES=2, RST_OUT=A5
module tb_rv_gpio;
  localparam int NB = 12;
  localparam logic [4:0] ADATA = 5'h00, ADIR = 5'h04, AOUT = 5'h08, ACLR = 5'h0C,
                         ATGL = 5'h10, ARISE = 5'h14, AFALL = 5'h18, AFLAG = 5'h1C;
  logic          clk = 0, reset = 1, cs = 0, rdy = 0, re = 0, irq;
  logic [4:0]    adr = 0;
  logic [3:0]    we = 0;
  logic [31:0]   dw = 0, dr;
  logic [NB-1:0] pin = 0, pout, poe;
  logic          rd_pend = 0, started = 0;
  logic [31:0]   exp_q[$];
  int            ncmp = 0, nbad = 0;

  rv_gpio #(.NBITS(NB), .SYNC_STAGES(2), .RST_OUT(32'hA5)) dut (
    .clk(clk), .reset(reset), .adr(adr), .cs(cs), .rdy(rdy), .we(we), .re(re),
    .dw(dw), .dr(dr), .irq(irq), .pin(pin), .pout(pout), .poe(poe));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
    ncmp++;
    if (act !== e) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic c, input logic y, input logic [4:0] ad, input logic [3:0] w,
                    input logic r, input logic [31:0] d, input logic [31:0] e);
    cs = c; rdy = y; adr = ad; we = w; re = r; dw = d;
    if (c & y & r & ~reset) exp_q.push_back(e);
    cyc();
    cs = 0; rdy = 0; we = 0; re = 0;
  endtask

  task automatic wr(input logic [4:0] ad, input logic [3:0] w, input logic [31:0] d);
    op(1, 1, ad, w, 0, d, 0);
  endtask

  task automatic rdx(input logic [4:0] ad, input logic [31:0] e);
    op(1, 1, ad, 4'b0, 1, 0, e);
  endtask

  always @(posedge clk) rd_pend <= cs & rdy & re & ~reset;

  always @(negedge clk)
    if (started) begin
      if (rd_pend) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rd_data", dr, exp_q.pop_front());
      end else chk("dr_idle", dr, 32'h0);
`ifndef RV_GPIO_IRQ_EN
      chk("irq_off", {31'h0, irq}, 32'h0);
`endif
    end

  initial begin
    repeat (2) cyc();
    reset = 0;
    started = 1;
    chk("rst_pout", 32'(pout), 32'h0A5);
    chk("rst_poe", 32'(poe), 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_dr", dr, 32'h0);
    // DATA / SET / CLR / TGL sequence
    wr(ADATA, 4'b0001, 32'h0000_00F0);
    wr(AOUT, 4'b1111, 32'h03);
    wr(ACLR, 4'b1111, 32'h30);
    wr(ATGL, 4'b1111, 32'h81);
    chk("pout_seq", 32'(pout), 32'h042);
    rdx(AOUT, 32'h042);
    cyc();
    // byte lane 1 only
    wr(ADATA, 4'b0010, 32'hFFFF_FFFF);
    rdx(AOUT, 32'hF42);
    wr(ADIR, 4'b1111, 32'h0000_FFFF);
    chk("poe_dir", 32'(poe), 32'hFFF);
    rdx(ADIR, 32'h0000_0FFF);
    rdx(ACLR, 32'h0);
    rdx(ATGL, 32'h0);
    // unqualified accesses are ignored
    op(0, 1, ADATA, 4'b1111, 0, 32'h0, 0);
    op(1, 0, ADATA, 4'b1111, 0, 32'h0, 0);
    op(1, 0, AOUT, 4'b0000, 1, 32'h0, 0);
    rdx(AOUT, 32'hF42);
    // read and SET in the same cycle return the pre-write value
    op(1, 1, AOUT, 4'b1111, 1, 32'h0000_000F, 32'hF42);
    rdx(AOUT, 32'hF4F);
    // synchroniser latency
    pin = 12'h5A3;
    repeat (3) cyc();
    rdx(ADATA, 32'h5A3);
    pin = 12'h111;
    rdx(ADATA, 32'h5A3);
    rdx(ADATA, 32'h5A3);
    rdx(ADATA, 32'h111);
    // reset mid-read
    reset = 1;
    rdx(ADATA, 32'h0);
    reset = 0;
    chk("mid_rst_pout", 32'(pout), 32'h0A5);
    chk("mid_rst_poe", 32'(poe), 32'h0);
    rdx(ADATA, 32'h0);
    rdx(AOUT, 32'h0A5);
`ifdef RV_GPIO_IRQ_EN
    pin = 12'h002;
    repeat (4) cyc();
    wr(ARISE, 4'b1111, 32'h1);
    wr(AFALL, 4'b1111, 32'h2);
    pin = 12'h001;
    repeat (3) cyc();
    chk("irq_early", {31'h0, irq}, 32'h0);
    cyc();
    chk("irq_set", {31'h0, irq}, 32'h1);
    rdx(AFLAG, 32'h3);
    wr(AFLAG, 4'b1111, 32'h1);
    rdx(AFLAG, 32'h2);
    chk("irq_hold", {31'h0, irq}, 32'h1);
    wr(AFLAG, 4'b1111, 32'h2);
    chk("irq_lag", {31'h0, irq}, 32'h1);
    cyc();
    chk("irq_clr", {31'h0, irq}, 32'h0);
    pin = 12'h000;
    repeat (4) cyc();
    pin = 12'h001;
    repeat (2) cyc();
    wr(AFLAG, 4'b1111, 32'h1);
    rdx(AFLAG, 32'h1);
`else
    wr(ARISE, 4'b1111, 32'hFF);
    wr(AFALL, 4'b1111, 32'hFF);
    pin = 12'hFFF;
    repeat (4) cyc();
    pin = 12'h000;
    repeat (4) cyc();
    rdx(ARISE, 32'h0);
    rdx(AFALL, 32'h0);
    rdx(AFLAG, 32'h0);
`endif
    repeat (3) cyc();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
